// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard unit for the 5-stage MIPS core. The core has no forwarding, so this
// block is its only hazard protection. It tracks the destination registers of
// the instructions in EX, MEM and WB, and it stalls fetch/decode when the
// instruction in ID reads one of them. It also squashes wrong-path
// instructions after a taken branch (resolved in MEM) or a jump (resolved in
// ID).
//
// Parameters:
//   PIPE_DEPTH     - scoreboard slots (slot0=EX, slot1=MEM, slot2=WB), 2..4
//   BRANCH_PENALTY - flush cycles after a taken branch, 1..7
//
// Ports:
//   clk              in   core clock, rising edge
//   reset            in   asynchronous active-low reset
//   id_valid         in   ID stage holds a real instruction
//   id_rs / id_rt    in   source register fields of the ID instruction
//   id_uses_rs/rt    in   ID instruction actually reads rs / rt
//   id_reg_write     in   ID instruction writes a register
//   id_write_reg     in   final destination register of the ID instruction
//   id_jump          in   ID instruction is j/jal/jr
//   mem_branch_taken in   branch in MEM resolved taken
//   stall            out  hold PC and IF/ID
//   flush            out  clear IF/ID (write NOP)
//   bubble           out  load NOP into ID/EX
//   stall_count      out  stall-cycle statistic
//   flush_count      out  flush-event statistic
//
// Optional feature: define HAZARD_STATS_EN to build the saturating 16-bit
// statistics counters. Without it both statistic ports read 16'h0000 and no
// counter flops exist.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int PIPE_DEPTH     = 3,
    parameter int BRANCH_PENALTY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_reg_write,
    input  logic [4:0]  id_write_reg,
    input  logic        id_jump,
    input  logic        mem_branch_taken,
    output logic        stall,
    output logic        flush,
    output logic        bubble,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Flush cycles still owed after the cycle in which the branch is seen.
    localparam logic [2:0] RELOAD = 3'(BRANCH_PENALTY - 1);

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [PIPE_DEPTH-1:0] slot_vld_q, slot_vld_d;
    logic [4:0]            slot_reg_q [PIPE_DEPTH];
    logic [4:0]            slot_reg_d [PIPE_DEPTH];

    logic rs_hit, rt_hit, hazard;
    logic in_flush, flush_raw, stall_raw, bubble_raw;

    // Every valid slot counts, including WB: the register file writes on the
    // same edge ID would read it, so ID has to wait for it to drop out.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (slot_vld_q[k] && (slot_reg_q[k] == id_rs)) rs_hit = 1'b1;
            if (slot_vld_q[k] && (slot_reg_q[k] == id_rt)) rt_hit = 1'b1;
        end
        hazard = id_valid &&
                 ((id_uses_rs && (id_rs != 5'd0) && rs_hit) ||
                  (id_uses_rt && (id_rt != 5'd0) && rt_hit));
    end

    assign in_flush   = (state_q == FLUSH);
    assign flush_raw  = mem_branch_taken | id_jump | in_flush;
    // A squashed instruction never stalls, so flush masks the hazard.
    assign stall_raw  = hazard & ~flush_raw;
    assign bubble_raw = stall_raw | mem_branch_taken | in_flush;

    // Outputs are forced low while reset is held so that nothing upstream
    // can leak a stall or flush through the combinational path.
    assign stall  = reset & stall_raw;
    assign flush  = reset & flush_raw;
    assign bubble = reset & bubble_raw;

    // Scoreboard shift. A stalled or bubbled ID instruction does not enter EX,
    // so it never occupies a slot. On a taken branch the instruction moving
    // from EX into MEM is on the wrong path and is dropped.
    always_comb begin
        slot_vld_d    = '0;
        slot_reg_d[0] = id_write_reg;
        slot_vld_d[0] = id_valid & id_reg_write & (id_write_reg != 5'd0) & ~bubble_raw;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            slot_vld_d[k] = slot_vld_q[k-1];
            slot_reg_d[k] = slot_reg_q[k-1];
        end
        if (mem_branch_taken) slot_vld_d[1] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_vld_q <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) slot_reg_q[k] <= 5'd0;
        end else begin
            slot_vld_q <= slot_vld_d;
            for (int k = 0; k < PIPE_DEPTH; k++) slot_reg_q[k] <= slot_reg_d[k];
        end
    end

    // Flush FSM. The branch cycle itself flushes combinationally; FLUSH
    // covers the remaining BRANCH_PENALTY-1 cycles. A new taken branch while
    // flushing restarts the countdown. A jump only ever flushes one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_branch_taken && (BRANCH_PENALTY > 1)) begin
                    state_d = FLUSH;
                    cnt_d   = RELOAD;
                end
            end
            FLUSH: begin
                if (mem_branch_taken) begin
                    cnt_d = RELOAD;
                end else if (cnt_q == 3'd1) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        flush_prev_q;

    // flush_count counts events: only the first cycle of a flush run.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_raw && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (flush_raw && !flush_prev_q && (flush_cnt_q != 16'hFFFF))
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= 16'd0;
            flush_cnt_q  <= 16'd0;
            flush_prev_q <= 1'b0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            flush_prev_q <= flush_raw;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = 16'h0000;
    assign flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int PD = 3;
    localparam int BP = 3;
`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_reg_write;
    logic [4:0]  id_write_reg;
    logic        id_jump;
    logic        mem_branch_taken;
    logic        stall;
    logic        flush;
    logic        bubble;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .PIPE_DEPTH     (PD),
        .BRANCH_PENALTY (BP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .id_valid         (id_valid),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rs       (id_uses_rs),
        .id_uses_rt       (id_uses_rt),
        .id_reg_write     (id_reg_write),
        .id_write_reg     (id_write_reg),
        .id_jump          (id_jump),
        .mem_branch_taken (mem_branch_taken),
        .stall            (stall),
        .flush            (flush),
        .bubble           (bubble),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    task automatic drive(input bit v, input bit urs, input int rs, input bit urt,
                         input int rt, input bit rw, input int wr, input bit j,
                         input bit mbt);
        id_valid         = v;
        id_uses_rs       = urs;
        id_rs            = 5'(rs);
        id_uses_rt       = urt;
        id_rt            = 5'(rt);
        id_reg_write     = rw;
        id_write_reg     = 5'(wr);
        id_jump          = j;
        mem_branch_taken = mbt;
    endtask

    task automatic clr_in();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clr_in();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
    endtask

    // Outputs during reset, then three quiet cycles with empty slots.
    task automatic test_reset();
        clr_in();
        reset = 1'b0;
        #3;
        checks++;
        if ({stall, flush, bubble} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold: {stall,flush,bubble}=%b expected 000", {stall, flush, bubble});
        end
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            // Reads of registers that no one has produced must not stall.
            drive(1, 1, 5, 1, 6, 0, 0, 0, 0);
            @(negedge clk);
            checks++;
            if ({stall, flush, bubble} !== 3'b000) begin
                errors++;
                $display("FAIL reset_release_c%0d: {stall,flush,bubble}=%b expected 000", i, {stall, flush, bubble});
            end
            next_cycle();
        end
        checks++;
        if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: stall_count=%0d flush_count=%0d expected 0 0", stall_count, flush_count);
        end
        clr_in();
    endtask

    // Producer of $t0 directly ahead of a consumer: PD stall cycles.
    task automatic test_raw_stall();
        apply_reset();
        drive(1, 0, 0, 0, 0, 1, 8, 0, 0);
        @(negedge clk);
        checks++;
        if ({stall, flush, bubble} !== 3'b000) begin
            errors++;
            $display("FAIL raw_producer: {stall,flush,bubble}=%b expected 000", {stall, flush, bubble});
        end
        next_cycle();
        drive(1, 1, 8, 0, 0, 1, 9, 0, 0);
        for (int i = 0; i < PD; i++) begin
            @(negedge clk);
            checks++;
            if ({stall, flush, bubble} !== 3'b101) begin
                errors++;
                $display("FAIL raw_stall_c%0d: {stall,flush,bubble}=%b expected 101", i, {stall, flush, bubble});
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if ({stall, flush, bubble} !== 3'b000) begin
            errors++;
            $display("FAIL raw_release: {stall,flush,bubble}=%b expected 000", {stall, flush, bubble});
        end
        next_cycle();
        // The consumer issued and wrote $9; a reader of $9 on rt must stall.
        drive(1, 0, 0, 1, 9, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({stall, flush, bubble} !== 3'b101) begin
            errors++;
            $display("FAIL raw_rt_chain: {stall,flush,bubble}=%b expected 101", {stall, flush, bubble});
        end
        next_cycle();
        clr_in();
    endtask

    // Writes to and reads of $0 never create a hazard.
    task automatic test_reg_zero();
        apply_reset();
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
            @(negedge clk);
            checks++;
            if ({stall, flush, bubble} !== 3'b000) begin
                errors++;
                $display("FAIL reg_zero_c%0d: {stall,flush,bubble}=%b expected 000", i, {stall, flush, bubble});
            end
            next_cycle();
        end
        clr_in();
    endtask

    // Taken branch: 3 flush cycles, and the concurrent RAW never stalls.
    task automatic test_branch_flush();
        apply_reset();
        drive(1, 0, 0, 0, 0, 1, 9, 0, 0);
        next_cycle();
        for (int i = 0; i < BP + 1; i++) begin
            drive(1, 1, 9, 0, 0, 0, 0, 0, (i == 0));
            @(negedge clk);
            checks++;
            if (i < BP) begin
                if ({stall, flush, bubble} !== 3'b011) begin
                    errors++;
                    $display("FAIL branch_flush_c%0d: {stall,flush,bubble}=%b expected 011", i, {stall, flush, bubble});
                end
            end else begin
                if ({stall, flush, bubble} !== 3'b000) begin
                    errors++;
                    $display("FAIL branch_end: {stall,flush,bubble}=%b expected 000", {stall, flush, bubble});
                end
            end
            next_cycle();
        end
        clr_in();
    endtask

    // Jump alone, jump+branch together, and a branch extending the flush.
    task automatic test_jump_branch();
        logic [2:0] exp_a [4];
        logic [2:0] exp_b [5];
        exp_a = '{3'b011, 3'b011, 3'b011, 3'b000};
        exp_b = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b000};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, (i == 0), (i == 0));
            @(negedge clk);
            checks++;
            if ({stall, flush, bubble} !== exp_a[i]) begin
                errors++;
                $display("FAIL jmp_br_c%0d: {stall,flush,bubble}=%b expected %b", i, {stall, flush, bubble}, exp_a[i]);
            end
            next_cycle();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, (i == 0), (i <= 1));
            @(negedge clk);
            checks++;
            if ({stall, flush, bubble} !== exp_b[i]) begin
                errors++;
                $display("FAIL jmp_br_ext_c%0d: {stall,flush,bubble}=%b expected %b", i, {stall, flush, bubble}, exp_b[i]);
            end
            next_cycle();
        end
        // A jump with a live RAW hazard flushes for one cycle, no stall.
        drive(1, 0, 0, 0, 0, 1, 12, 0, 0);
        next_cycle();
        drive(1, 1, 12, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checks++;
        if ({stall, flush, bubble} !== 3'b010) begin
            errors++;
            $display("FAIL jump_only: {stall,flush,bubble}=%b expected 010", {stall, flush, bubble});
        end
        next_cycle();
        drive(1, 1, 12, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({stall, flush, bubble} !== 3'b101) begin
            errors++;
            $display("FAIL jump_after: {stall,flush,bubble}=%b expected 101", {stall, flush, bubble});
        end
        next_cycle();
        clr_in();
    endtask

    // Statistics: 5 stall cycles, 2 branch flushes, then reset mid-flush.
    task automatic test_stats();
        int exp_sc;
        int exp_fc;
        exp_sc = STATS ? 5 : 0;
        exp_fc = STATS ? 2 : 0;
        apply_reset();
        drive(1, 0, 0, 0, 0, 1, 10, 0, 0);
        next_cycle();
        clr_in();
        next_cycle();
        drive(1, 1, 10, 0, 0, 0, 0, 0, 0);
        repeat (3) next_cycle();
        drive(1, 0, 0, 0, 0, 1, 11, 0, 0);
        next_cycle();
        drive(1, 1, 11, 0, 0, 0, 0, 0, 0);
        repeat (4) next_cycle();
        for (int b = 0; b < 2; b++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
            next_cycle();
            clr_in();
            repeat (3) next_cycle();
        end
        @(negedge clk);
        checks++;
        if (stall_count !== 16'(exp_sc) || flush_count !== 16'(exp_fc)) begin
            errors++;
            $display("FAIL stats_counts: stall_count=%0d flush_count=%0d expected %0d %0d",
                     stall_count, flush_count, exp_sc, exp_fc);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        next_cycle();
        clr_in();
        @(negedge clk);
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL mid_flush_pre: flush=%b expected 1", flush);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({stall, flush, bubble} !== 3'b000 || stall_count !== 16'd0 || flush_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_flush_reset: {stall,flush,bubble}=%b counts=%0d/%0d expected 000 0/0",
                     {stall, flush, bubble}, stall_count, flush_count);
        end
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({stall, flush, bubble} !== 3'b000) begin
            errors++;
            $display("FAIL residual_flush: {stall,flush,bubble}=%b expected 000", {stall, flush, bubble});
        end
        next_cycle();
    endtask

    // Random traffic against a queue-based model of the in-flight writers.
    task automatic test_random();
        int unsigned mq[$];
        int  fl_left;
        int  exp_sc, exp_fc;
        bit  prev_f;
        bit  v, urs, urt, rw, j, mbt, hz, ef, es, eb;
        int  rs, rt, wr;
        apply_reset();
        mq = {};
        for (int k = 0; k < PD; k++) mq.push_back(0);
        fl_left = 0;
        exp_sc  = 0;
        exp_fc  = 0;
        prev_f  = 1'b0;
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            urs = $urandom_range(0, 1) != 0;
            urt = $urandom_range(0, 1) != 0;
            rw  = $urandom_range(0, 1) != 0;
            rs  = $urandom_range(0, 3);
            rt  = $urandom_range(0, 3);
            wr  = $urandom_range(0, 3);
            j   = ($urandom_range(0, 15) == 0);
            mbt = ($urandom_range(0, 11) == 0);
            drive(v, urs, rs, urt, rt, rw, wr, j, mbt);
            hz = 1'b0;
            foreach (mq[k]) begin
                if (mq[k] != 0 && urs && mq[k] == rs) hz = 1'b1;
                if (mq[k] != 0 && urt && mq[k] == rt) hz = 1'b1;
            end
            hz = hz & v;
            ef = mbt | j | (fl_left > 0);
            es = hz & !ef;
            eb = es | mbt | (fl_left > 0);
            @(negedge clk);
            checks++;
            if ({stall, flush, bubble} !== {es, ef, eb}) begin
                errors++;
                $display("FAIL random_n%0d: {stall,flush,bubble}=%b expected %b", n, {stall, flush, bubble}, {es, ef, eb});
            end
            if (STATS) begin
                if (es && exp_sc < 65535) exp_sc++;
                if (ef && !prev_f && exp_fc < 65535) exp_fc++;
            end
            prev_f = ef;
            void'(mq.pop_back());
            if (mbt) mq[0] = 0;
            mq.push_front((v && rw && wr != 0 && !eb) ? wr : 0);
            fl_left = mbt ? BP - 1 : ((fl_left > 0) ? fl_left - 1 : 0);
            next_cycle();
        end
        clr_in();
        @(negedge clk);
        checks++;
        if (stall_count !== 16'(exp_sc) || flush_count !== 16'(exp_fc)) begin
            errors++;
            $display("FAIL random_counts: stall_count=%0d flush_count=%0d expected %0d %0d",
                     stall_count, flush_count, exp_sc, exp_fc);
        end
        next_cycle();
    endtask

    initial begin
        reset = 1'b0;
        clr_in();
        test_reset();
        test_raw_stall();
        test_reg_zero();
        test_branch_flush();
        test_jump_branch();
        test_stats();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors + 1, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Hazard unit beside the IF/ID and ID/EX pipeline registers of the 5-stage MIPS core; the core has no forwarding, so this block is the only hazard protection.
- Tracks the destination registers of in-flight instructions (EX, MEM, WB).
- Stalls fetch/decode on read-after-write hazards.
- Squashes wrong-path instructions after a taken branch (resolved in MEM) or a jump (resolved in ID).
- Drives the hold/flush controls of PC_Register and the pipeline registers.

Parameters:
PIPE_DEPTH, 3, number of scoreboard slots: slot0=EX, slot1=MEM, slot2=WB. Legal range 2..4.
BRANCH_PENALTY, 3, cycles flush is asserted after a taken branch. Legal range 1..7.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  5  rs field of the ID instruction
id_rt  input  5  rt field of the ID instruction
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
id_reg_write  input  1  ID instruction writes a register
id_write_reg  input  5  final destination register (after RegDst/jal mux)
id_jump  input  1  ID instruction is j/jal/jr
mem_branch_taken  input  1  branch in MEM resolved taken
stall  output  1  hold PC and IF/ID
flush  output  1  clear IF/ID (write NOP)
bubble  output  1  load NOP into ID/EX
stall_count  output  16  stall-cycle statistic (optional feature)
flush_count  output  16  flush-event statistic (optional feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - all slots invalid; FSM in IDLE; flush counter=0; statistics=0.
  - stall=flush=bubble=0 during reset and on the first cycle after release.
- Slot = {valid, reg[4:0]}.
- Hazard (combinational):
  - Condition: id_valid & ((id_uses_rs & id_rs!=0 & id_rs matches any valid slot) | (id_uses_rt & id_rt!=0 & id_rt matches any valid slot)).
  - Register 0 never causes a hazard.
  - The WB slot counts: the register file writes on the edge, so ID must wait for it.
- Outputs (combinational from state and inputs):
  - flush = mem_branch_taken | id_jump | (state==FLUSH).
  - stall = hazard & !flush. Flush has priority: a squashed instruction never stalls.
  - bubble = stall | mem_branch_taken | (state==FLUSH).
- Scoreboard update on each rising edge:
  - slot[k+1] <= slot[k]; the last slot drops out.
  - slot0 <= {1, id_write_reg} only if id_valid & id_reg_write & id_write_reg!=0 & !stall & !bubble; otherwise invalid.
  - If mem_branch_taken: slot1 <= invalid, i.e. the EX instruction younger than the branch is squashed and not propagated.
- Flush FSM:
  - States: IDLE, FLUSH; 3-bit counter cnt.
  - IDLE -> FLUSH when mem_branch_taken and BRANCH_PENALTY>1; cnt <= BRANCH_PENALTY-1.
  - FLUSH: cnt decrements each cycle; go to IDLE when cnt reaches 1.
  - mem_branch_taken during FLUSH reloads cnt <= BRANCH_PENALTY-1.
  - id_jump causes exactly one flush cycle (combinational); it does not enter FLUSH.
  - Jump and branch in the same cycle: branch wins (older instruction) and the FSM loads as above; the jump is squashed.
- Timing:
  - Stall latency is 0 cycles (same cycle as the hazard appears).
  - A producer directly ahead of a consumer costs PIPE_DEPTH stall cycles.
- Reset mid-flush or mid-stall: immediate return to IDLE with slots cleared; no residual flush.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - stall_count increments on each cycle with stall=1.
  - flush_count increments on each rising edge of the flush condition (new event, not per cycle).
  - Both counters are 16-bit, saturate at 16'hFFFF, and are cleared by reset.
- When undefined: both ports are present and tied to 16'h0000; no counter flops are synthesised.

Test Plan:
- Reset held low, then released; all inputs 0 -> stall=flush=bubble=0; slots empty for 3 cycles.
- add $t0 issues (write_reg=8), next ID uses rs=8 -> stall=1 and bubble=1 for 3 cycles, then 0; the consumer issues on cycle 4.
- Producer writes $0, consumer reads rs=0 -> stall never asserted; slot0 stays invalid.
- mem_branch_taken pulse with BRANCH_PENALTY=3 -> flush=1 for 3 cycles, bubble=1 for 3 cycles, EX slot invalidated; a concurrent RAW hazard on the squashed instruction does not stall.
- id_jump and mem_branch_taken in the same cycle -> 3-cycle flush; a second branch_taken on the second flush cycle extends flush to 4 cycles total.
- HAZARD_STATS_EN defined: 5 stall cycles then 2 branch flushes -> stall_count=5, flush_count=2; reset asserted mid-flush -> flush=0 immediately and counters=0.
